// File: rtl/neopix_chan_sched.sv
// Shares one WS2812 byte serializer between two buffered pixel channels: picks a channel
// holding a full frame (round-robin on contention), streams it, latches the line, then acks.
module neopix_chan_sched #(
  parameter int unsigned NUM_LEDS      = 2,
  parameter int unsigned MIN_LED_PULSE = 20000,
  parameter int unsigned ADDR_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        frame_rdy,
  output logic [1:0]        frame_ack,
  output logic              rd_sel,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic [7:0]        ser_data,
  output logic              ser_valid,
  input  logic              ser_ready,
  input  logic              ser_busy,
  input  logic              ser_out,
  output logic [1:0]        do_out,
  output logic              busy,
  output logic              cur_ch
);

  localparam int unsigned FrameLen = NUM_LEDS * 3;
  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(FrameLen - 1);
  localparam int unsigned CntW = (MIN_LED_PULSE > 1) ? $clog2(MIN_LED_PULSE) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(MIN_LED_PULSE - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StLoad, StDrain, StLatch} state_e;

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [1:0]        mask_q, mask_d;
  logic              cur_q, cur_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              first_q, first_d;
  logic [CntW-1:0]   cnt_q, cnt_d;

  logic [1:0] eligible;
  logic       grant_valid;
  logic       grant_ch;
  logic       handshake;
  logic       latch_done;

  // Channel acked last cycle is held off for one cycle so its buffer can drop frame_rdy.
  always_comb begin
    eligible    = frame_rdy & ~mask_q;
    grant_valid = |eligible;
    grant_ch    = (eligible == 2'b11) ? ~last_q : eligible[1];
    handshake   = (state_q == StLoad) && ser_ready;
    latch_done  = (state_q == StLatch) && (cnt_q == CntLast);
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (grant_valid) state_d = StFetch;
      StFetch: state_d = StLoad;
      StLoad: begin
        if (handshake) state_d = (addr_q == LastAddr) ? StDrain : StFetch;
      end
      StDrain: if (!ser_busy) state_d = StLatch;
      StLatch: if (latch_done) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= 1'b1;
      mask_q  <= 2'b00;
      cur_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= 8'h00;
      first_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      last_q  <= last_d;
      mask_q  <= mask_d;
      cur_q   <= cur_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      first_q <= first_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    last_d  = last_q;
    mask_d  = frame_ack;
    cur_d   = cur_q;
    addr_d  = addr_q;
    data_d  = data_q;
    first_d = first_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          cur_d  = grant_ch;
          addr_d = '0;
        end
      end
      StFetch: first_d = 1'b1;
      StLoad: begin
        // rd_data is only guaranteed on the first LOAD cycle; keep a copy for stalls.
        if (first_q) begin
          data_d  = rd_data;
          first_d = 1'b0;
        end
        if (handshake && (addr_q != LastAddr)) addr_d = addr_q + 1'b1;
      end
      StDrain: cnt_d = '0;
      StLatch: begin
        cnt_d = cnt_q + 1'b1;
        if (latch_done) last_d = cur_q;
      end
      default: ;
    endcase
  end

  // Output logic
  always_comb begin
    busy      = (state_q != StIdle);
    ser_valid = (state_q == StLoad);
    ser_data  = 8'h00;
    do_out    = 2'b00;
    frame_ack = 2'b00;
    rd_sel    = cur_q;
    rd_addr   = addr_q;
    cur_ch    = cur_q;
    if (state_q == StLoad) ser_data = first_q ? rd_data : data_q;
    if ((state_q == StFetch) || (state_q == StLoad) || (state_q == StDrain)) begin
      do_out[cur_q] = ser_out;
    end
    frame_ack[cur_q] = latch_done;
  end

endmodule

// File: tb/tb_neopix_chan_sched.sv
// Scoreboard bench for neopix_chan_sched: stimulus pushes expected bytes/acks, a negedge
// monitor pops and compares them as the DUT hands bytes to the serializer model.
module tb_neopix_chan_sched;

  localparam int unsigned NumLeds  = 2;
  localparam int unsigned Pulse    = 20;
  localparam int unsigned AddrW    = 8;
  localparam int unsigned FrameLen = NumLeds * 3;

  logic             clk;
  logic             rst;
  logic [1:0]       frame_rdy;
  logic [1:0]       frame_ack;
  logic             rd_sel;
  logic [AddrW-1:0] rd_addr;
  logic [7:0]       rd_data;
  logic [7:0]       ser_data;
  logic             ser_valid;
  logic             ser_ready;
  logic             ser_busy;
  logic             ser_out;
  logic [1:0]       do_out;
  logic             busy;
  logic             cur_ch;

  neopix_chan_sched #(
    .NUM_LEDS     (NumLeds),
    .MIN_LED_PULSE(Pulse),
    .ADDR_W       (AddrW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .frame_rdy(frame_rdy),
    .frame_ack(frame_ack),
    .rd_sel   (rd_sel),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .ser_data (ser_data),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .ser_busy (ser_busy),
    .ser_out  (ser_out),
    .do_out   (do_out),
    .busy     (busy),
    .cur_ch   (cur_ch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic             ch;
    logic [AddrW-1:0] addr;
    logic [7:0]       data;
  } exp_t;

  exp_t exp_q[$];
  bit   ack_q[$];
  exp_t e_mon;
  bit   ach;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state
  int cyc = 0;
  int hs_cnt = 0;
  int ack_total = 0;
  bit last_ack_ch = 1'b0;
  int fall_cyc = 0;
  bit low_ok = 1'b0;
  int stray = 0;
  int stall_seen = 0;
  int idle_run = 0;
  int last_gap = 0;
  bit prev_ser_busy = 1'b0;
  bit prev_busy = 1'b0;

  // Stimulus / model state
  logic [7:0] frame_buf [2][FrameLen];
  int  hs_seen = 0;
  int  ack_seen = 0;
  int  busy_left = 0;
  int  drain_k = 4;
  int  stall_left = 0;
  int  stall_addr = 0;
  bit  phase = 1'b0;
  bit  last_sel = 1'b0;
  int  last_addr = 0;
  logic [1:0] auto_clr = 2'b11;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      idle_run = 0;
      stray = 0;
    end else begin
      if (!busy) idle_run++;
      else begin
        if (!prev_busy) last_gap = idle_run;
        idle_run = 0;
      end
      if (prev_ser_busy && !ser_busy) begin
        fall_cyc = cyc;
        low_ok = 1'b1;
      end else if (do_out != 2'b00) begin
        low_ok = 1'b0;
      end
      if (((do_out & ~(2'b01 << cur_ch)) != 2'b00) || (!busy && (do_out != 2'b00))) stray++;

      if (ser_valid && ser_ready) begin
        hs_cnt++;
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL byte_unexpected: got ch=%0d addr=%0d data=%02h, required no byte",
                   rd_sel, rd_addr, ser_data);
        end else begin
          e_mon = exp_q.pop_front();
          if ({rd_sel, rd_addr, ser_data} !== e_mon) begin
            miscompares++;
            $display("FAIL byte: got ch=%0d addr=%0d data=%02h, required ch=%0d addr=%0d data=%02h",
                     rd_sel, rd_addr, ser_data, e_mon.ch, e_mon.addr, e_mon.data);
          end
        end
      end else if (ser_valid && (exp_q.size() != 0)) begin
        stall_seen++;
        vectors++;
        if (ser_data !== exp_q[0].data) begin
          miscompares++;
          $display("FAIL stall_hold: got data=%02h, required %02h", ser_data, exp_q[0].data);
        end
      end

      if (frame_ack != 2'b00) begin
        vectors++;
        if (ack_q.size() == 0) begin
          miscompares++;
          $display("FAIL ack_unexpected: got frame_ack=%b, required none", frame_ack);
        end else begin
          ach = ack_q.pop_front();
          if (frame_ack !== (2'b01 << ach)) begin
            miscompares++;
            $display("FAIL ack: got frame_ack=%b, required %b", frame_ack, 2'b01 << ach);
          end
        end
        vectors++;
        if (!low_ok || ((cyc - fall_cyc) != Pulse)) begin
          miscompares++;
          $display("FAIL latch: got %0d cycles (low_ok=%0d), required %0d low cycles",
                   cyc - fall_cyc, low_ok, Pulse);
        end
        vectors++;
        if (stray != 0) begin
          miscompares++;
          $display("FAIL do_out_route: got %0d stray cycles, required 0", stray);
        end
        stray = 0;
        last_ack_ch = frame_ack[1];
        ack_total++;
      end
    end
    prev_ser_busy = ser_busy;
    prev_busy = busy;
  end

  // One cycle of stimulus: serializer model, registered buffer read, frame_rdy refill.
  task automatic tick();
    @(posedge clk);
    #1;
    if (rst) begin
      busy_left = 0;
      stall_left = 0;
    end else if (hs_cnt != hs_seen) begin
      busy_left = drain_k;
    end else if (busy_left > 0) begin
      busy_left--;
    end
    hs_seen = hs_cnt;
    ser_busy = (busy_left != 0);
    phase = ~phase;
    ser_out = ser_busy & phase;
    rd_data = (last_addr < FrameLen) ? frame_buf[last_sel][last_addr] : 8'h00;
    last_sel = rd_sel;
    last_addr = int'(rd_addr);
    if (ser_valid && (int'(rd_addr) == stall_addr) && (stall_left > 0)) begin
      ser_ready = 1'b0;
      stall_left--;
    end else begin
      ser_ready = 1'b1;
    end
    if (ack_total != ack_seen) begin
      if (auto_clr[last_ack_ch]) frame_rdy[last_ack_ch] = 1'b0;
      ack_seen = ack_total;
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic push_frame(input bit ch);
    for (int i = 0; i < FrameLen; i++) begin
      exp_q.push_back({ch, AddrW'(i), frame_buf[ch][i]});
    end
    ack_q.push_back(ch);
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n = 0;
    while (((exp_q.size() != 0) || (ack_q.size() != 0) || busy) && (n < budget)) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s_timeout: got %0d bytes/%0d acks outstanding, required 0",
               name, exp_q.size(), ack_q.size());
      exp_q.delete();
      ack_q.delete();
    end
  endtask

  task automatic wait_acks(input int target, input int budget, input string name);
    int n = 0;
    while ((ack_total < target) && (n < budget)) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s_ack_timeout: got %0d acks, required %0d", name, ack_total, target);
    end
  endtask

  task automatic wait_grant(input bit ch, input int budget, input string name);
    int n = 0;
    while (!(busy && (cur_ch == ch)) && (n < budget)) begin
      tick();
      n++;
    end
    vectors++;
    if (n >= budget) begin
      miscompares++;
      $display("FAIL %s_grant_timeout: got cur_ch=%0d busy=%0d, required ch%0d", name, cur_ch,
               busy, ch);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {14'h0, frame_ack, rd_sel, rd_addr, ser_data, ser_valid, do_out, busy, cur_ch},
          32'h0);
  endtask

  initial begin
    int base;
    logic [7:0] pat0 [FrameLen];
    logic [7:0] pat1 [FrameLen];
    pat0 = '{8'haa, 8'h55, 8'h00, 8'haa, 8'h55, 8'h00};
    pat1 = '{8'h00, 8'h55, 8'haa, 8'h00, 8'h55, 8'haa};
    for (int i = 0; i < FrameLen; i++) begin
      frame_buf[0][i] = pat0[i];
      frame_buf[1][i] = pat1[i];
    end
    rst = 1'b1;
    frame_rdy = 2'b00;
    rd_data = 8'h00;
    ser_ready = 1'b1;
    ser_busy = 1'b0;
    ser_out = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset_state");
    rst = 1'b0;
    tick();

    // Single frame, with grant and first-byte latency
    push_frame(1'b0);
    frame_rdy = 2'b01;
    tick();
    check("grant_latency", {30'h0, busy, cur_ch}, 32'h2);
    check("fetch_no_valid", {31'h0, ser_valid}, 32'h0);
    tick();
    check("first_valid", {31'h0, ser_valid}, 32'h1);
    run_until_done(400, "single");

    // Simultaneous ready from reset: ch0 first, one idle cycle between frames
    rst = 1'b1;
    tick();
    rst = 1'b0;
    push_frame(1'b0);
    push_frame(1'b1);
    frame_rdy = 2'b11;
    run_until_done(800, "simul");
    check("simul_gap", last_gap, 32'd1);

    // Same channel stays ready: re-grant only after the one-cycle holdoff
    auto_clr = 2'b10;
    base = ack_total;
    push_frame(1'b0);
    push_frame(1'b0);
    frame_rdy = 2'b01;
    wait_acks(base + 1, 400, "holdoff");
    wait_grant(1'b0, 20, "holdoff");
    frame_rdy[0] = 1'b0;
    run_until_done(400, "holdoff");
    check("holdoff_gap", last_gap, 32'd2);

    // Fairness: ch0 permanently ready, ch1 raised during each ch0 frame
    base = ack_total;
    push_frame(1'b0);
    push_frame(1'b1);
    push_frame(1'b0);
    push_frame(1'b1);
    frame_rdy = 2'b01;
    wait_grant(1'b0, 20, "fair0");
    frame_rdy[1] = 1'b1;
    wait_acks(base + 2, 800, "fair1");
    wait_grant(1'b0, 20, "fair2");
    frame_rdy[1] = 1'b1;
    frame_rdy[0] = 1'b0;
    run_until_done(800, "fair");
    auto_clr = 2'b11;

    // Backpressure on byte 3
    base = stall_seen;
    stall_addr = 3;
    stall_left = 5;
    push_frame(1'b0);
    frame_rdy = 2'b01;
    run_until_done(400, "stall");
    check("stall_cycles", stall_seen - base, 32'd5);

    // Long drain before latch
    drain_k = 30;
    push_frame(1'b1);
    frame_rdy = 2'b10;
    run_until_done(600, "drain");
    drain_k = 4;

    // Reset mid-frame on ch1, then both ready
    base = ack_total;
    push_frame(1'b1);
    frame_rdy = 2'b10;
    begin
      int n = 0;
      while (!(ser_valid && (rd_addr == 2)) && (n < 100)) begin
        tick();
        n++;
      end
      check("reset_reach_byte2", {31'h0, ser_valid}, 32'h1);
    end
    rst = 1'b1;
    exp_q.delete();
    ack_q.delete();
    tick();
    check_reset_outputs("reset_midframe");
    check("reset_no_ack", ack_total, base);
    rst = 1'b0;
    push_frame(1'b0);
    push_frame(1'b1);
    frame_rdy = 2'b11;
    run_until_done(800, "after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion, required finish");
    $fatal(1);
  end

endmodule

// File: doc/neopix_chan_sched.md
# neopix_chan_sched

Frame scheduler that shares one WS2812 byte serializer between the two SPI-fed pixel channels (chip-select 0 and 1). It picks a channel that holds a complete received frame, using round-robin when both are ready. It then streams that frame's bytes from the channel buffer into the serializer, routes the serial bit to the selected channel's data-out pin, and holds the line low for the latch period. Finally it acknowledges the frame so the buffer can be refilled. It sits between the per-channel SPI receive buffers and the shared serializer inside the top level.

## Interface
- NUM_LEDS, 2, LEDs per channel; frame length N = NUM_LEDS*3 bytes
- MIN_LED_PULSE, 20000, latch low time in clk cycles after the last bit of a frame
- ADDR_W, 8, buffer address width; 2^ADDR_W >= N is required

- clk  in  1  system clock; the only clock
- rst  in  1  reset, synchronous, active-high
- frame_rdy  in  2  per channel, level: buffer holds a complete frame
- frame_ack  out  2  per channel, one-cycle pulse: frame consumed, buffer may refill
- rd_sel  out  1  channel buffer being read
- rd_addr  out  ADDR_W  byte address into the selected buffer
- rd_data  in  8  buffer read data, valid exactly 1 cycle after rd_addr/rd_sel
- ser_data  out  8  byte to serializer, MSB sent first
- ser_valid  out  1  ser_data valid
- ser_ready  in  1  serializer accepts byte when ser_valid&ser_ready
- ser_busy  in  1  serializer still shifting accepted bits
- ser_out  in  1  serializer's WS2812-encoded bit stream
- do_out  out  2  per-channel LED data pins
- busy  out  1  high in every state except IDLE
- cur_ch  out  1  channel currently granted

## Operation
- States: IDLE, FETCH, LOAD, DRAIN, LATCH.
- Reset (any state, including mid-frame):
  - next state IDLE; last-served pointer = 1, so ch0 wins first.
  - All outputs 0: frame_ack, rd_sel, rd_addr, ser_data, ser_valid, do_out, busy, cur_ch.
  - No frame_ack is issued for an aborted frame.
- IDLE: form eligible = frame_rdy & ~mask.
  - mask = channel acked in the previous cycle (one-cycle holdoff); mask is 0 otherwise.
  - One eligible channel: grant it. Both eligible: grant the channel ≠ last-served.
  - On grant: cur_ch = rd_sel = granted channel, rd_addr = 0, go FETCH.
  - No eligible channel: stay in IDLE.
- FETCH: rd_addr presented for one cycle, then go LOAD.
- LOAD: ser_data = rd_data (registered on entry, held stable), ser_valid = 1.
  - Hold until handshake.
  - On handshake with rd_addr == N-1: ser_valid drops, go DRAIN.
  - On handshake otherwise: rd_addr += 1, ser_valid drops, go FETCH.
- DRAIN: wait for ser_busy == 0, then go LATCH with the latch counter = 0.
- LATCH: counter increments each cycle.
  - At counter == MIN_LED_PULSE-1: pulse frame_ack[cur_ch], last-served = cur_ch, go IDLE.
- do_out[cur_ch] = ser_out in FETCH, LOAD and DRAIN; 0 in LATCH and IDLE.
- do_out of the non-granted channel is always 0.
- frame_rdy deasserting mid-frame is ignored: the frame completes and is acked.
- frame_rdy is sampled only in IDLE.
- rd_addr width ADDR_W; it never exceeds N-1 and does not wrap.

## Timing
- Grant: 1 cycle after frame_rdy is seen in IDLE.
- First ser_valid: 2 cycles after the IDLE grant cycle (FETCH, then LOAD).
- Per byte, minimum 2 cycles (FETCH + LOAD) with ser_ready held high.
- Each ser_ready stall cycle adds 1 cycle.
- Latch: exactly MIN_LED_PULSE cycles of do_out low between ser_busy falling and the frame_ack cycle.
- Earliest next grant:
  - Other channel: the cycle after frame_ack.
  - Same channel: 2 cycles after frame_ack (holdoff).
- ser_data is stable and ser_valid monotonic while waiting for ser_ready.

## Test plan
- Single frame:
  - Setup: NUM_LEDS=2, MIN_LED_PULSE=20; ch0 buffer holds aa 55 00 aa 55 00; frame_rdy=01; serializer model with ready always high.
  - Required: ser_data sequence aa,55,00,aa,55,00 at addrs 0..5.
  - Required: do_out[1] stays 0; exactly 20 cycles of do_out[0] low after ser_busy falls.
  - Required: one frame_ack=01 pulse.
- Simultaneous ready:
  - Stimulus: frame_rdy=11 from reset.
  - Required: ch0 frame (aa 55 00 aa 55 00) first, then ch1 frame (00 55 aa …), one ack each.
  - Required: busy drops for at most 1 cycle between frames.
- Fairness:
  - Stimulus: ch0 frame_rdy held permanently high, ch1 raised during the ch0 frame.
  - Required: grants alternate 0,1,0,1; ch0 is never served twice in a row while ch1 is ready.
- Backpressure:
  - Stimulus: ser_ready low for 5 cycles on byte 3.
  - Required: ser_data holds 0xaa and ser_valid stays high for the full 5 cycles; no byte skipped or duplicated.
- Drain and latch:
  - Stimulus: ser_busy held high 30 cycles after the last handshake.
  - Required: LATCH count starts only after ser_busy falls.
  - Required: frame_ack occurs exactly MIN_LED_PULSE cycles later.
- Reset mid-frame:
  - Stimulus: rst asserted during byte 2 of a ch1 frame.
  - Required: next cycle all outputs 0, no frame_ack.
  - Required: after release with frame_rdy=11, ch0 is granted first.
